// File: rtl/ysyx_24100029_alu_issue_if.sv
// Decoder-to-issue and issue-to-execute handshake bundle.
//   master : decoder/execute side (drives instruction fields, in_valid, out_ready)
//   slave  : issue stage (drives in_ready, out_valid and the issued operation)
interface ysyx_24100029_alu_issue_if #(
  parameter int unsigned BW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7_5;
  logic [BW-1:0] pc;
  logic [BW-1:0] rs1_data;
  logic [BW-1:0] rs2_data;
  logic [BW-1:0] imm;
  logic [4:0]    rd;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] d1;
  logic [BW-1:0] d2;
  logic [3:0]    choice;
  logic [4:0]    out_rd;
  logic          out_wen;
  logic          out_branch;
  logic          out_br_inv;
  logic          out_illegal;

  modport master (
    output in_valid, opcode, funct3, funct7_5, pc, rs1_data, rs2_data, imm, rd, out_ready,
    input  in_ready, out_valid, d1, d2, choice, out_rd, out_wen, out_branch, out_br_inv,
           out_illegal
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7_5, pc, rs1_data, rs2_data, imm, rd, out_ready,
    output in_ready, out_valid, d1, d2, choice, out_rd, out_wen, out_branch, out_br_inv,
           out_illegal
  );
endinterface

// File: rtl/ysyx_24100029_alu_issue.sv
// ALU issue stage: decodes RV32I fields into an ALU op code plus operands and
// hands them to execute through a 2-entry (main + skid) valid/ready buffer.
//   clk, rst (sync, active-high), flush (drop all buffered entries)
//   bus : slave side of ysyx_24100029_alu_issue_if (decoder in, execute out)
module ysyx_24100029_alu_issue #(
  parameter int unsigned BW = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  ysyx_24100029_alu_issue_if.slave    bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] CH_ADD  = 4'd0;
  localparam logic [3:0] CH_SUB  = 4'd1;
  localparam logic [3:0] CH_AND  = 4'd3;
  localparam logic [3:0] CH_OR   = 4'd4;
  localparam logic [3:0] CH_XOR  = 4'd5;
  localparam logic [3:0] CH_SLT  = 4'd6;
  localparam logic [3:0] CH_SLTU = 4'd7;
  localparam logic [3:0] CH_NE   = 4'd8;
  localparam logic [3:0] CH_SLL  = 4'd9;
  localparam logic [3:0] CH_SRL  = 4'd10;
  localparam logic [3:0] CH_SRA  = 4'd11;
  localparam logic [3:0] CH_DEF  = 4'd15;

  typedef struct packed {
    logic [BW-1:0] d1;
    logic [BW-1:0] d2;
    logic [3:0]    choice;
    logic [4:0]    rd;
    logic          wen;
    logic          branch;
    logic          br_inv;
    logic          illegal;
  } issue_t;

  localparam issue_t RST_ENTRY = '{d1: '0, d2: '0, choice: 4'd15, rd: '0,
                                   wen: 1'b0, branch: 1'b0, br_inv: 1'b0, illegal: 1'b0};

  // Register-register / register-immediate funct3 table; alt picks sub/sra.
  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'b000:  code = alt ? CH_SUB : CH_ADD;
      3'b001:  code = CH_SLL;
      3'b010:  code = CH_SLT;
      3'b011:  code = CH_SLTU;
      3'b100:  code = CH_XOR;
      3'b101:  code = alt ? CH_SRA : CH_SRL;
      3'b110:  code = CH_OR;
      default: code = CH_AND;
    endcase
    return code;
  endfunction

  issue_t dec_c;
  logic   writes_rd_c;

  // Combinational decode of the instruction currently offered by the decoder.
  always_comb begin
    dec_c        = RST_ENTRY;
    writes_rd_c  = 1'b0;
    dec_c.rd     = bus.rd;
    dec_c.choice = CH_ADD;
    case (bus.opcode)
      OPC_OP: begin
        dec_c.choice = alu_code(bus.funct3, bus.funct7_5);
        dec_c.d1     = bus.rs1_data;
        dec_c.d2     = bus.rs2_data;
        writes_rd_c  = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_c.choice = alu_code(bus.funct3, bus.funct7_5 & (bus.funct3 == 3'b101));
        dec_c.d1     = bus.rs1_data;
        dec_c.d2     = bus.imm;
        writes_rd_c  = 1'b1;
      end
      OPC_LUI: begin
        dec_c.d2    = bus.imm;
        writes_rd_c = 1'b1;
      end
      OPC_AUIPC: begin
        dec_c.d1    = bus.pc;
        dec_c.d2    = bus.imm;
        writes_rd_c = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // ALU produces the link address pc+4.
        dec_c.d1    = bus.pc;
        dec_c.d2    = BW'(32'd4);
        writes_rd_c = 1'b1;
      end
      OPC_LOAD: begin
        dec_c.d1    = bus.rs1_data;
        dec_c.d2    = bus.imm;
        writes_rd_c = 1'b1;
      end
      OPC_STORE: begin
        dec_c.d1 = bus.rs1_data;
        dec_c.d2 = bus.imm;
      end
      OPC_BRANCH: begin
        if (bus.funct3[2:1] == 2'b01) begin
          dec_c.choice  = CH_DEF;
          dec_c.illegal = 1'b1;
        end else begin
          dec_c.choice = bus.funct3[2] ? (bus.funct3[1] ? CH_SLTU : CH_SLT) : CH_NE;
          dec_c.d1     = bus.rs1_data;
          dec_c.d2     = bus.rs2_data;
          dec_c.branch = 1'b1;
          // eq/ge/geu are taken on a zero compare result.
          dec_c.br_inv = bus.funct3[2] ? bus.funct3[0] : ~bus.funct3[0];
        end
      end
      default: begin
        dec_c.choice  = CH_DEF;
        dec_c.illegal = 1'b1;
      end
    endcase
    dec_c.wen = writes_rd_c & (bus.rd != 5'd0);
  end

  issue_t main_q, main_d;
  issue_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept_c, drain_c;

  assign accept_c = bus.in_valid & bus.in_ready;
  assign drain_c  = main_valid_q & bus.out_ready;

  // Skid-buffer next state: skid refills main first, so FIFO order holds.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain_c || !main_valid_q) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept_c;
        if (accept_c) main_d = dec_c;
      end
    end else if (accept_c) begin
      skid_d       = dec_c;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= RST_ENTRY;
      skid_q       <= RST_ENTRY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // rst gating keeps the stage closed while reset is held.
  assign bus.in_ready    = in_ready_q & ~rst;
  assign bus.out_valid   = main_valid_q;
  assign bus.d1          = main_q.d1;
  assign bus.d2          = main_q.d2;
  assign bus.choice      = main_q.choice;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_wen     = main_q.wen;
  assign bus.out_branch  = main_q.branch;
  assign bus.out_br_inv  = main_q.br_inv;
  assign bus.out_illegal = main_q.illegal;

endmodule
